sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Sits between the CPU memory ports and the two physical SRAMs: base RAM (code plus data) and ext RAM (data).
- Decodes data virtual addresses to a RAM region and drives active-low SRAM strobes.
- Sequences two-phase writes.
- Arbitrates base RAM between instruction fetch and data access, stalling the CPU on conflict.

Parameters:
- BASE_ADDR, 32'h8000_0000, base RAM window start.
- EXT_ADDR, 32'h8040_0000, ext RAM window start.
- WIN_BITS, 22, log2 of window size (4 MiB each); PADDR = vaddr[WIN_BITS-1:2].

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- I_CE  in  1  fetch request
- I_VADDR  in  32  fetch address
- I_RDATA  out  32  fetched instruction
- D_CE  in  1  data request
- D_WE  in  1  1 = write
- D_BE  in  4  byte enables, active-high
- D_VADDR  in  32  data address
- D_WDATA  in  32  store data
- D_RDATA  out  32  load data
- STALL  out  1  CPU must hold all request inputs stable while high
- ADDR_ERR  out  1  sticky out-of-window flag
- BASE_RDATA  in  32  base SRAM read data
- BASE_WDATA  out  32  base SRAM write data
- BASE_ADDR_O  out  20  base SRAM address
- BASE_BE_N  out  4  byte enables, active-low
- BASE_CE_N  out  1  chip enable, active-low
- BASE_OE_N  out  1  output enable, active-low
- BASE_WE_N  out  1  write enable, active-low
- EXT_RDATA, EXT_WDATA, EXT_ADDR_O, EXT_BE_N, EXT_CE_N, EXT_OE_N, EXT_WE_N: same widths and meaning for ext SRAM

Behaviour:
- Reset (synchronous, RST=1 at edge):
  - both FSMs to IDLE; d_hold=0; ADDR_ERR=0.
  - While RST=1: all *_CE_N/*_OE_N/*_WE_N=1, *_BE_N=4'hF, STALL=0.
- Decode:
  - hit_base = vaddr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS].
  - hit_ext = vaddr[31:WIN_BITS] == EXT_ADDR[31:WIN_BITS].
  - Fetch is only valid to base.
  - Any CE with no legal hit: no SRAM access, read data 0, ADDR_ERR set at the next edge and held until RST.
- Reads: SRAM is asynchronous; read data is passed combinationally in the serving cycle; OE_N=0, WE_N=1, BE_N=0.
- Base FSM, states B_IDLE, B_WR, B_INST:
  - B_IDLE, data read to base with I_CE=1 (conflict): base serves data; BASE_RDATA latched into d_hold; STALL=1; go to B_INST.
  - B_IDLE, data write to base: setup cycle, address/data/BE driven with CE_N=0, WE_N=1, OE_N=1; STALL=1; go to B_WR.
  - B_IDLE, otherwise: serve fetch if I_CE; serve a data read if no fetch; STALL=0.
  - B_WR: WE_N=0 with address/data held; STALL=I_CE. Go to B_INST if I_CE, else B_IDLE.
  - B_INST: serve fetch; D_RDATA=d_hold (0 after a write); STALL=0; go to B_IDLE.
- Ext FSM, states E_IDLE, E_WR:
  - E_IDLE, write: setup, STALL=1, go to E_WR.
  - E_WR: WE_N=0, STALL=0 (ext path), go to E_IDLE.
  - Ext reads: 0 wait states, no stall.
- STALL is the OR of base and ext contributions.
- A data access counts as complete in the cycle where STALL drops; the held request is never re-issued.
- Write pulse length is exactly one cycle. WE_N is registered from state, so it is glitch-free.
- Reset mid-write: write aborted, WE_N=1 in the reset cycle; memory content at that address is undefined.

Decomposition:
- Shared package sram_pkg:
  - state enums base_state_t / ext_state_t.
  - window constants.
  - typedef sram_if_t (addr, wdata, be_n, ce_n, oe_n, we_n).
- One sub-module, sram_wr_seq: a two-state write sequencer, instantiated once per SRAM.
- Decode and mux logic stays in the top.

Test Plan:
- Reset then idle: RST=1 two cycles → all *_N=1, BE_N=F, STALL=0, ADDR_ERR=0.
- Fetch 0x8000_0010 with BASE_RDATA=0x2408_0001, no data request → BASE_ADDR_O=0x00004, I_RDATA=0x2408_0001, STALL=0, zero latency.
- Conflict: fetch 0x8000_0020 plus load 0x8000_1000 (BASE_RDATA=0xDEAD_BEEF) → cycle N: STALL=1, addr 0x00400. Cycle N+1: addr 0x00008, STALL=0, D_RDATA=0xDEAD_BEEF.
- Ext store 0x8040_0008, BE=4'b0011, data 0x1234_5678 → cycle N: EXT_WE_N=1, STALL=1, EXT_BE_N=4'b1100. Cycle N+1: EXT_WE_N=0, STALL=0. Cycle N+2: WE_N=1. Fetch unaffected throughout.
- Base store with fetch → STALL=1 for 2 cycles (setup, pulse), fetch served in the third cycle; without fetch → STALL=1 for 1 cycle only.
- Load 0x9000_0000 → no CE_N asserted, D_RDATA=0, ADDR_ERR=1 from the next cycle, persists until RST. RST asserted during B_WR → BASE_WE_N=1 that cycle, state B_IDLE.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types, window constants and bus helpers for the SRAM arbiter.
package sram_pkg;

    localparam logic [31:0] BASE_WIN_ADDR = 32'h8000_0000;
    localparam logic [31:0] EXT_WIN_ADDR  = 32'h8040_0000;
    localparam int          WIN_BITS_DEF  = 22;
    localparam int          PADDR_W       = 20;

    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_WR   = 2'd1,
        B_INST = 2'd2
    } base_state_t;

    typedef enum logic {
        E_IDLE = 1'b0,
        E_WR   = 1'b1
    } ext_state_t;

    typedef enum logic {
        WS_IDLE  = 1'b0,
        WS_PULSE = 1'b1
    } wr_state_t;

    // Everything the arbiter drives toward one asynchronous SRAM.
    typedef struct packed {
        logic [PADDR_W-1:0] addr;
        logic [31:0]        wdata;
        logic [3:0]         be_n;
        logic               ce_n;
        logic               oe_n;
        logic               we_n;
    } sram_if_t;

    localparam sram_if_t SRAM_IDLE = '{
        addr:  '0,
        wdata: '0,
        be_n:  4'hF,
        ce_n:  1'b1,
        oe_n:  1'b1,
        we_n:  1'b1
    };

    // True when vaddr falls inside the 2**bits window starting at win.
    function automatic logic win_hit(input logic [31:0] vaddr,
                                     input logic [31:0] win,
                                     input int          bits);
        return (vaddr >> bits) == (win >> bits);
    endfunction

    // Full-word asynchronous read cycle.
    function automatic sram_if_t rd_bus(input logic [PADDR_W-1:0] a);
        sram_if_t b;
        b      = SRAM_IDLE;
        b.addr = a;
        b.be_n = 4'h0;
        b.ce_n = 1'b0;
        b.oe_n = 1'b0;
        return b;
    endfunction

    // Write setup cycle: chip selected, outputs off, no write strobe yet.
    function automatic sram_if_t setup_bus(input logic [PADDR_W-1:0] a,
                                           input logic [31:0]        wd,
                                           input logic [3:0]         be);
        sram_if_t b;
        b       = SRAM_IDLE;
        b.addr  = a;
        b.wdata = wd;
        b.be_n  = ~be;
        b.ce_n  = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/sram_wr_seq.sv
// Two-phase write sequencer: captures the write payload in the setup cycle
// and produces a one-cycle, register-driven WE_N pulse in the next cycle.
module sram_wr_seq
    import sram_pkg::*;
(
    input  logic               clk,
    input  logic               srst,
    input  logic               start_i,
    input  logic [PADDR_W-1:0] addr_i,
    input  logic [31:0]        wdata_i,
    input  logic [3:0]         be_n_i,
    output logic [PADDR_W-1:0] addr_o,
    output logic [31:0]        wdata_o,
    output logic [3:0]         be_n_o,
    output logic               we_n_o
);

    wr_state_t          state_q;
    logic [PADDR_W-1:0] addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_n_q;
    logic               we_n_q;

    // Setup -> pulse -> idle; WE_N comes straight from a flop so it cannot glitch.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= WS_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_n_q  <= 4'hF;
            we_n_q  <= 1'b1;
        end else begin
            case (state_q)
                WS_IDLE: begin
                    if (start_i) begin
                        state_q <= WS_PULSE;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        be_n_q  <= be_n_i;
                        we_n_q  <= 1'b0;
                    end
                end
                WS_PULSE: begin
                    state_q <= WS_IDLE;
                    we_n_q  <= 1'b1;
                end
                default: begin
                    state_q <= WS_IDLE;
                    we_n_q  <= 1'b1;
                end
            endcase
        end
    end

    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign be_n_o  = be_n_q;
    assign we_n_o  = we_n_q;

endmodule

// File: rtl/sram_arbiter.sv
// CPU-to-SRAM arbiter: decodes data addresses onto base/ext SRAM, sequences
// two-phase writes and shares base SRAM between fetch and data, stalling the
// CPU when both need it in the same cycle.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_WIN_ADDR,
    parameter logic [31:0] EXT_ADDR  = EXT_WIN_ADDR,
    parameter int          WIN_BITS  = WIN_BITS_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        I_CE,
    input  logic [31:0] I_VADDR,
    output logic [31:0] I_RDATA,
    input  logic        D_CE,
    input  logic        D_WE,
    input  logic [3:0]  D_BE,
    input  logic [31:0] D_VADDR,
    input  logic [31:0] D_WDATA,
    output logic [31:0] D_RDATA,
    output logic        STALL,
    output logic        ADDR_ERR,
    input  logic [31:0] BASE_RDATA,
    output logic [31:0] BASE_WDATA,
    output logic [19:0] BASE_ADDR_O,
    output logic [3:0]  BASE_BE_N,
    output logic        BASE_CE_N,
    output logic        BASE_OE_N,
    output logic        BASE_WE_N,
    input  logic [31:0] EXT_RDATA,
    output logic [31:0] EXT_WDATA,
    output logic [19:0] EXT_ADDR_O,
    output logic [3:0]  EXT_BE_N,
    output logic        EXT_CE_N,
    output logic        EXT_OE_N,
    output logic        EXT_WE_N
);

    // ---------------- decode ----------------
    logic               i_hit, d_hit_base, d_hit_ext;
    logic               i_ok, d_base_rd, d_base_wr, d_ext_rd, d_ext_wr, err_now;
    logic [PADDR_W-1:0] i_paddr, d_paddr;

    assign i_hit      = win_hit(I_VADDR, BASE_ADDR, WIN_BITS);
    assign d_hit_base = win_hit(D_VADDR, BASE_ADDR, WIN_BITS);
    assign d_hit_ext  = win_hit(D_VADDR, EXT_ADDR, WIN_BITS);
    assign i_paddr    = I_VADDR[WIN_BITS-1:2];
    assign d_paddr    = D_VADDR[WIN_BITS-1:2];

    assign i_ok      = I_CE & i_hit;
    assign d_base_rd = D_CE & d_hit_base & ~D_WE;
    assign d_base_wr = D_CE & d_hit_base & D_WE;
    assign d_ext_rd  = D_CE & d_hit_ext & ~D_WE;
    assign d_ext_wr  = D_CE & d_hit_ext & D_WE;
    // Fetches may only target base; data may target either window.
    assign err_now   = (I_CE & ~i_hit) | (D_CE & ~d_hit_base & ~d_hit_ext);

    // ---------------- state ----------------
    base_state_t base_q, base_d;
    ext_state_t  ext_q, ext_d;
    logic [31:0] d_hold_q, d_hold_d;
    logic        addr_err_q;

    sram_if_t    base_bus, ext_bus;
    logic        base_stall, ext_stall;
    logic        base_wr_start, ext_wr_start;
    logic [31:0] i_rdata_b, base_drdata, ext_drdata;

    logic [PADDR_W-1:0] base_wr_addr, ext_wr_addr;
    logic [31:0]        base_wr_wdata, ext_wr_wdata;
    logic [3:0]         base_wr_be_n, ext_wr_be_n;
    logic               base_wr_we_n, ext_wr_we_n;

    sram_wr_seq u_base_wr (
        .clk     (CLK),
        .srst    (RST),
        .start_i (base_wr_start),
        .addr_i  (d_paddr),
        .wdata_i (D_WDATA),
        .be_n_i  (~D_BE),
        .addr_o  (base_wr_addr),
        .wdata_o (base_wr_wdata),
        .be_n_o  (base_wr_be_n),
        .we_n_o  (base_wr_we_n)
    );

    sram_wr_seq u_ext_wr (
        .clk     (CLK),
        .srst    (RST),
        .start_i (ext_wr_start),
        .addr_i  (d_paddr),
        .wdata_i (D_WDATA),
        .be_n_i  (~D_BE),
        .addr_o  (ext_wr_addr),
        .wdata_o (ext_wr_wdata),
        .be_n_o  (ext_wr_be_n),
        .we_n_o  (ext_wr_we_n)
    );

    // Base SRAM: pick fetch or data each cycle, defer the fetch on conflict.
    always_comb begin
        base_d        = base_q;
        d_hold_d      = d_hold_q;
        base_bus      = SRAM_IDLE;
        base_stall    = 1'b0;
        base_wr_start = 1'b0;
        i_rdata_b     = '0;
        base_drdata   = '0;
        case (base_q)
            B_IDLE: begin
                if (d_base_wr) begin
                    base_bus      = setup_bus(d_paddr, D_WDATA, D_BE);
                    base_stall    = 1'b1;
                    base_wr_start = 1'b1;
                    d_hold_d      = '0;
                    base_d        = B_WR;
                end else if (d_base_rd && I_CE) begin
                    // Data wins the port; its word is parked for next cycle.
                    base_bus    = rd_bus(d_paddr);
                    base_drdata = BASE_RDATA;
                    d_hold_d    = BASE_RDATA;
                    base_stall  = 1'b1;
                    base_d      = B_INST;
                end else if (i_ok) begin
                    base_bus  = rd_bus(i_paddr);
                    i_rdata_b = BASE_RDATA;
                end else if (d_base_rd) begin
                    base_bus    = rd_bus(d_paddr);
                    base_drdata = BASE_RDATA;
                end
            end
            B_WR: begin
                base_bus.addr  = base_wr_addr;
                base_bus.wdata = base_wr_wdata;
                base_bus.be_n  = base_wr_be_n;
                base_bus.ce_n  = 1'b0;
                base_bus.oe_n  = 1'b1;
                base_bus.we_n  = base_wr_we_n;
                base_stall     = I_CE;
                base_d         = I_CE ? B_INST : B_IDLE;
            end
            B_INST: begin
                // The held data request completes here; it is not re-decoded.
                if (i_ok) begin
                    base_bus  = rd_bus(i_paddr);
                    i_rdata_b = BASE_RDATA;
                end
                base_drdata = d_hold_q;
                base_d      = B_IDLE;
            end
            default: base_d = B_IDLE;
        endcase
        if (RST) begin
            base_bus      = SRAM_IDLE;
            base_stall    = 1'b0;
            base_wr_start = 1'b0;
            i_rdata_b     = '0;
            base_drdata   = '0;
        end
    end

    // Ext SRAM: zero-wait reads, one stall cycle per write.
    always_comb begin
        ext_d        = ext_q;
        ext_bus      = SRAM_IDLE;
        ext_stall    = 1'b0;
        ext_wr_start = 1'b0;
        ext_drdata   = '0;
        case (ext_q)
            E_IDLE: begin
                if (d_ext_wr) begin
                    ext_bus      = setup_bus(d_paddr, D_WDATA, D_BE);
                    ext_stall    = 1'b1;
                    ext_wr_start = 1'b1;
                    ext_d        = E_WR;
                end else if (d_ext_rd) begin
                    ext_bus    = rd_bus(d_paddr);
                    ext_drdata = EXT_RDATA;
                end
            end
            E_WR: begin
                ext_bus.addr  = ext_wr_addr;
                ext_bus.wdata = ext_wr_wdata;
                ext_bus.be_n  = ext_wr_be_n;
                ext_bus.ce_n  = 1'b0;
                ext_bus.oe_n  = 1'b1;
                ext_bus.we_n  = ext_wr_we_n;
                ext_d         = E_IDLE;
            end
            default: ext_d = E_IDLE;
        endcase
        if (RST) begin
            ext_bus      = SRAM_IDLE;
            ext_stall    = 1'b0;
            ext_wr_start = 1'b0;
            ext_drdata   = '0;
        end
    end

    // FSM state, conflict hold register and sticky address-error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            base_q     <= B_IDLE;
            ext_q      <= E_IDLE;
            d_hold_q   <= '0;
            addr_err_q <= 1'b0;
        end else begin
            base_q     <= base_d;
            ext_q      <= ext_d;
            d_hold_q   <= d_hold_d;
            addr_err_q <= addr_err_q | err_now;
        end
    end

    // ---------------- outputs ----------------
    assign I_RDATA  = i_rdata_b;
    assign D_RDATA  = base_drdata | ext_drdata;
    assign STALL    = base_stall | ext_stall;
    assign ADDR_ERR = addr_err_q;

    assign BASE_ADDR_O = base_bus.addr;
    assign BASE_WDATA  = base_bus.wdata;
    assign BASE_BE_N   = base_bus.be_n;
    assign BASE_CE_N   = base_bus.ce_n;
    assign BASE_OE_N   = base_bus.oe_n;
    assign BASE_WE_N   = base_bus.we_n;

    assign EXT_ADDR_O = ext_bus.addr;
    assign EXT_WDATA  = ext_bus.wdata;
    assign EXT_BE_N   = ext_bus.be_n;
    assign EXT_CE_N   = ext_bus.ce_n;
    assign EXT_OE_N   = ext_bus.oe_n;
    assign EXT_WE_N   = ext_bus.we_n;

endmodule
